clause_table_walker: RTL and testbench

Read-side sequencer for the clause table. On `start` it walks table indices from 0 upward, driving the table's combinational read port. Each valid clause index it finds is presented to a downstream consumer, such as a BCP/implication unit, over a valid/ready handshake. The walk ends when the table reports `error` (index past the fill pointer) or the last table slot has been emitted.

---
 rtl/clause_walker_pkg.sv | 31 +++
 rtl/clause_table_walker.sv | 157 +++++++++++++++
 tb/tb_clause_table_walker.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clause_walker_pkg.sv
//------------------------------------------------------------------------------
// Module  : clause_walker_pkg
// Brief   : Shared types and widths for the clause table walker.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef CLAUSE_TABLE_BITS
`define CLAUSE_TABLE_BITS 3
`endif
`ifndef CLAUSE_TABLE_SIZE
`define CLAUSE_TABLE_SIZE 8
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

package clause_walker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } walker_state_t;

    localparam int COUNT_BITS = `CLAUSE_TABLE_BITS + 1;

endpackage

`default_nettype wire

// File: rtl/clause_table_walker.sv
//------------------------------------------------------------------------------
// Module  : clause_table_walker
// Brief   : Walks the clause table from index 0 and streams each valid clause
//           index out over valid/ready. Optional CLAUSE_WALKER_SKIP_EN drops
//           entries equal to skip_clause.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef CLAUSE_TABLE_BITS
`define CLAUSE_TABLE_BITS 3
`endif
`ifndef CLAUSE_TABLE_SIZE
`define CLAUSE_TABLE_SIZE 8
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

import clause_walker_pkg::*;

module clause_table_walker #(
    parameter int TABLE_BITS  = `CLAUSE_TABLE_BITS,
    parameter int TABLE_SIZE  = `CLAUSE_TABLE_SIZE,
    parameter int CLAUSE_BITS = `MAX_CLAUSES_BITS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    output logic                   tbl_read,
    output logic [TABLE_BITS-1:0]  tbl_index,
    input  logic [CLAUSE_BITS-1:0] tbl_clause,
    input  logic                   tbl_error,
    output logic                   out_valid,
    output logic [CLAUSE_BITS-1:0] out_clause,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic [TABLE_BITS:0]    count
`ifdef CLAUSE_WALKER_SKIP_EN
    ,
    input  logic [CLAUSE_BITS-1:0] skip_clause
`endif
);

    localparam logic [TABLE_BITS-1:0] LAST_IDX = TABLE_BITS'(TABLE_SIZE - 1);

    walker_state_t            state_q, state_d;
    logic [TABLE_BITS-1:0]    idx_q, idx_d;
    logic [TABLE_BITS:0]      count_q, count_d;
    logic [CLAUSE_BITS-1:0]   out_clause_q, out_clause_d;
    logic                     out_valid_q, out_valid_d;
    logic                     last_q, last_d;
    logic                     skip_hit;

`ifdef CLAUSE_WALKER_SKIP_EN
    assign skip_hit = (tbl_clause == skip_clause);
`else
    assign skip_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            count_q      <= '0;
            out_clause_q <= '0;
            out_valid_q  <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            out_clause_q <= out_clause_d;
            out_valid_q  <= out_valid_d;
            last_q       <= last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        count_d      = count_q;
        out_clause_d = out_clause_q;
        out_valid_d  = out_valid_q;
        last_d       = last_q;

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (start && !abort) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    count_d = '0;
                end
            end
            FETCH: begin
                if (tbl_error) begin
                    state_d = DONE;
                end else if (skip_hit) begin
                    // Skipped entry: advance without emitting, same end rule as HOLD.
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    out_clause_d = tbl_clause;
                    out_valid_d  = 1'b1;
                    last_d       = (idx_q == LAST_IDX);
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    count_d     = count_q + 1'b1;
                    out_valid_d = 1'b0;
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Abort overrides any pending transition, including a same-cycle handshake.
        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            out_valid_d  = 1'b0;
            idx_d        = idx_q;
            count_d      = count_q;
            out_clause_d = out_clause_q;
            last_d       = last_q;
        end
    end

    assign tbl_read   = (state_q == FETCH);
    assign tbl_index  = idx_q;
    assign out_valid  = out_valid_q;
    assign out_clause = out_clause_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign count      = count_q;

endmodule

`default_nettype wire

// File: tb/tb_clause_table_walker.sv
//------------------------------------------------------------------------------
// Module  : tb_clause_table_walker
// Brief   : Directed self-checking bench for clause_table_walker with a
//           behavioural clause table (combinational read, fill pointer).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clause_table_walker;

    localparam int TB_TBITS = 3;
    localparam int TB_SIZE  = 8;
    localparam int TB_CBITS = 8;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic                tbl_read;
    logic [TB_TBITS-1:0] tbl_index;
    logic [TB_CBITS-1:0] tbl_clause;
    logic                tbl_error;
    logic                out_valid;
    logic [TB_CBITS-1:0] out_clause;
    logic                out_ready = 1'b0;
    logic                busy;
    logic                done;
    logic [TB_TBITS:0]   count;
`ifdef CLAUSE_WALKER_SKIP_EN
    logic [TB_CBITS-1:0] skip_clause = 8'hFF;
`endif

    logic [TB_CBITS-1:0] mem [TB_SIZE];
    logic [TB_TBITS:0]   fill = '0;

    int n_assert = 0;
    int n_fail   = 0;

    assign tbl_clause = mem[tbl_index];
    assign tbl_error  = ({1'b0, tbl_index} >= fill);

    always #5 clock = ~clock;

    clause_table_walker #(
        .TABLE_BITS (TB_TBITS),
        .TABLE_SIZE (TB_SIZE),
        .CLAUSE_BITS(TB_CBITS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .tbl_read   (tbl_read),
        .tbl_index  (tbl_index),
        .tbl_clause (tbl_clause),
        .tbl_error  (tbl_error),
        .out_valid  (out_valid),
        .out_clause (out_clause),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .count      (count)
`ifdef CLAUSE_WALKER_SKIP_EN
        ,
        .skip_clause(skip_clause)
`endif
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs until done is seen (bounded), recording accepted clauses.
    task automatic run_to_done(input int budget, output int n_out, output logic [TB_CBITS-1:0] got [TB_SIZE],
                               output logic saw_done, output logic idx0_reread);
        int fetches;
        n_out = 0;
        saw_done = 1'b0;
        idx0_reread = 1'b0;
        fetches = 0;
        for (int k = 0; k < TB_SIZE; k++) got[k] = '0;
        for (int c = 0; c < budget && !saw_done; c++) begin
            if (tbl_read) begin
                if (fetches > 0 && tbl_index == '0) idx0_reread = 1'b1;
                fetches++;
            end
            if (out_valid && out_ready && n_out < TB_SIZE) begin
                got[n_out] = out_clause;
                n_out++;
            end
            if (done) saw_done = 1'b1;
            else step();
        end
    endtask

    int                  n_out;
    logic [TB_CBITS-1:0] got [TB_SIZE];
    logic                saw_done;
    logic                idx0_reread;

    initial begin
        for (int k = 0; k < TB_SIZE; k++) mem[k] = '0;

        // Reset state
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_tbl_read",  {31'd0, tbl_read}, 32'd0);
        chk("rst_tbl_index", {29'd0, tbl_index}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_clause",{24'd0, out_clause}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_done",      {31'd0, done}, 32'd0);
        chk("rst_count",     {28'd0, count}, 32'd0);

        // start together with abort in IDLE: stays IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("startabort_busy", {31'd0, busy}, 32'd0);
        chk("startabort_read", {31'd0, tbl_read}, 32'd0);

        // Normal walk: 5, 9, 12
        mem[0] = 8'd5; mem[1] = 8'd9; mem[2] = 8'd12; fill = 4'd3;
        out_ready = 1'b1;
        start = 1'b1;
        step();                                   // N+1 FETCH idx0
        start = 1'b0;
        chk("nw_fetch_read", {31'd0, tbl_read}, 32'd1);
        chk("nw_fetch_idx",  {29'd0, tbl_index}, 32'd0);
        chk("nw_fetch_busy", {31'd0, busy}, 32'd1);
        chk("nw_fetch_ov",   {31'd0, out_valid}, 32'd0);
        step();                                   // N+2 HOLD 5
        chk("nw_ov1",  {31'd0, out_valid}, 32'd1);
        chk("nw_oc1",  {24'd0, out_clause}, 32'd5);
        chk("nw_rd1",  {31'd0, tbl_read}, 32'd0);
        start = 1'b1;                             // ignored mid-walk
        step();                                   // N+3 FETCH idx1
        start = 1'b0;
        chk("nw_cnt1", {28'd0, count}, 32'd1);
        chk("nw_idx1", {29'd0, tbl_index}, 32'd1);
        step();                                   // N+4 HOLD 9
        chk("nw_oc2",  {24'd0, out_clause}, 32'd9);
        chk("nw_ov2",  {31'd0, out_valid}, 32'd1);
        step();                                   // N+5 FETCH idx2
        step();                                   // N+6 HOLD 12
        chk("nw_oc3",  {24'd0, out_clause}, 32'd12);
        step();                                   // N+7 FETCH idx3 (error)
        chk("nw_err_read", {31'd0, tbl_read}, 32'd1);
        chk("nw_err_done", {31'd0, done}, 32'd0);
        step();                                   // N+8 DONE
        chk("nw_done", {31'd0, done}, 32'd1);
        chk("nw_cnt3", {28'd0, count}, 32'd3);
        step();                                   // IDLE
        chk("nw_done_pulse", {31'd0, done}, 32'd0);
        chk("nw_idle_busy",  {31'd0, busy}, 32'd0);
        chk("nw_cnt_hold",   {28'd0, count}, 32'd3);

        // Empty table
        fill = 4'd0;
        start = 1'b1;
        step();                                   // N+1 FETCH
        start = 1'b0;
        chk("em_busy1", {31'd0, busy}, 32'd1);
        chk("em_cnt0",  {28'd0, count}, 32'd0);
        step();                                   // N+2 DONE
        chk("em_done",  {31'd0, done}, 32'd1);
        chk("em_busy2", {31'd0, busy}, 32'd1);
        chk("em_ov",    {31'd0, out_valid}, 32'd0);
        step();                                   // N+3 IDLE
        chk("em_idle",  {31'd0, busy}, 32'd0);
        chk("em_cnt",   {28'd0, count}, 32'd0);

        // Backpressure: 7, 3
        mem[0] = 8'd7; mem[1] = 8'd3; fill = 4'd2;
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();                                   // HOLD 7
        for (int i = 0; i < 4; i++) begin
            chk("bp_oc", {24'd0, out_clause}, 32'd7);
            chk("bp_ov", {31'd0, out_valid}, 32'd1);
            chk("bp_rd", {31'd0, tbl_read}, 32'd0);
            step();
        end
        chk("bp_oc_last", {24'd0, out_clause}, 32'd7);
        out_ready = 1'b1;
        step();                                   // FETCH idx1
        chk("bp_cnt1", {28'd0, count}, 32'd1);
        step();                                   // HOLD 3
        chk("bp_oc2",  {24'd0, out_clause}, 32'd3);
        step();                                   // FETCH idx2 (error)
        step();                                   // DONE
        chk("bp_done", {31'd0, done}, 32'd1);
        chk("bp_cnt2", {28'd0, count}, 32'd2);
        step();

        // Full table: 1..8, ends via last flag
        for (int k = 0; k < TB_SIZE; k++) mem[k] = 8'(k + 1);
        fill = 4'd8;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_done(60, n_out, got, saw_done, idx0_reread);
        chk("full_done",  {31'd0, saw_done}, 32'd1);
        chk("full_nout",  32'(n_out), 32'd8);
        for (int k = 0; k < TB_SIZE; k++) chk("full_order", {24'd0, got[k]}, 32'(k + 1));
        chk("full_noreread", {31'd0, idx0_reread}, 32'd0);
        chk("full_cnt", {28'd0, count}, 32'd8);
        step();
        chk("full_idle", {31'd0, busy}, 32'd0);

        // Abort while the 2nd of 4 entries is presented
        mem[0] = 8'd11; mem[1] = 8'd22; mem[2] = 8'd33; mem[3] = 8'd44; fill = 4'd4;
        out_ready = 1'b1;
        start = 1'b1;
        step();                                   // FETCH 0
        start = 1'b0;
        step();                                   // HOLD 11
        step();                                   // FETCH 1
        step();                                   // HOLD 22
        chk("ab_oc2", {24'd0, out_clause}, 32'd22);
        abort = 1'b1;
        out_ready = 1'b0;
        step();
        abort = 1'b0;
        chk("ab_ov",   {31'd0, out_valid}, 32'd0);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_done", {31'd0, done}, 32'd0);
        chk("ab_cnt",  {28'd0, count}, 32'd1);
        step();
        chk("ab_nodone", {31'd0, done}, 32'd0);
        chk("ab_cnt_hold", {28'd0, count}, 32'd1);
        out_ready = 1'b1;
        start = 1'b1;
        step();                                   // restart from index 0
        start = 1'b0;
        chk("ab_re_idx", {29'd0, tbl_index}, 32'd0);
        chk("ab_re_read", {31'd0, tbl_read}, 32'd1);
        chk("ab_re_cnt", {28'd0, count}, 32'd0);
        run_to_done(40, n_out, got, saw_done, idx0_reread);
        chk("ab_re_done", {31'd0, saw_done}, 32'd1);
        chk("ab_re_first", {24'd0, got[0]}, 32'd11);
        chk("ab_re_cnt4", {28'd0, count}, 32'd4);
        step();

`ifdef CLAUSE_WALKER_SKIP_EN
        // Skip: 5, 9, 12 with skip_clause=9
        mem[0] = 8'd5; mem[1] = 8'd9; mem[2] = 8'd12; fill = 4'd3;
        skip_clause = 8'd9;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_done(40, n_out, got, saw_done, idx0_reread);
        chk("sk_done", {31'd0, saw_done}, 32'd1);
        chk("sk_nout", 32'(n_out), 32'd2);
        chk("sk_o0",   {24'd0, got[0]}, 32'd5);
        chk("sk_o1",   {24'd0, got[1]}, 32'd12);
        chk("sk_cnt",  {28'd0, count}, 32'd2);
        skip_clause = 8'hFF;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
